// File: rtl/parallel2serial_param.sv
`default_nettype none
// ============================================================================
// parallel2serial_param : WIDTH-bit parallel-to-serial converter with
// selectable bit order. Define PARALLEL2SERIAL_PARITY_EN to add an even-parity bit.
// Rev 1.0
// ============================================================================
module parallel2serial_param #(
  parameter  int WIDTH     = 8,
  parameter  int MSB_FIRST = 0,
  localparam int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic             parallel_begin,
  output logic             ready,
  output logic             busy,
  output logic             d,
  output logic             serial_start,
  output logic             serial_end,
  output logic [CNT_W-1:0] counter,
  output logic             overrun
);

`ifdef PARALLEL2SERIAL_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(FRAME - 1);
  localparam logic [0:0]       S_IDLE  = 1'b0;
  localparam logic [0:0]       S_SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_d;
  logic             r_start;
  logic             r_end;
  logic             r_ovr;

  logic             w_last;
  logic             w_ready;
  logic             w_load;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_first_bit;
  logic [WIDTH-1:0] w_load_sr;
  logic             w_sr_bit;
  logic [WIDTH-1:0] w_sr_shift;
  logic             w_next_bit;

  assign w_last    = (r_state == S_SHIFT) && (r_cnt == c_LAST);
  assign w_ready   = (r_state == S_IDLE) || w_last;
  assign w_load    = parallel_begin && w_ready;
  assign w_cnt_nxt = r_cnt + CNT_W'(1);

  // The shift register holds only the bits not yet placed on d.
  assign w_first_bit = (MSB_FIRST != 0) ? a[WIDTH-1] : a[0];
  assign w_load_sr   = (MSB_FIRST != 0) ? {a[WIDTH-2:0], 1'b0} : {1'b0, a[WIDTH-1:1]};
  assign w_sr_bit    = (MSB_FIRST != 0) ? r_sr[WIDTH-1] : r_sr[0];
  assign w_sr_shift  = (MSB_FIRST != 0) ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};

`ifdef PARALLEL2SERIAL_PARITY_EN
  logic r_par;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_par <= 1'b0;
    end else if (w_load) begin
      r_par <= ^a;
    end
  end

  assign w_next_bit = (w_cnt_nxt == CNT_W'(WIDTH)) ? r_par : w_sr_bit;
`else
  assign w_next_bit = w_sr_bit;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_d     <= 1'b0;
      r_start <= 1'b0;
      r_end   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= parallel_begin && !w_ready;
      if (w_load) begin
        r_state <= S_SHIFT;
        r_sr    <= w_load_sr;
        r_cnt   <= '0;
        r_d     <= w_first_bit;
        r_start <= 1'b1;
        r_end   <= 1'b0;
      end else if ((r_state == S_SHIFT) && !w_last) begin
        r_sr    <= w_sr_shift;
        r_cnt   <= w_cnt_nxt;
        r_d     <= w_next_bit;
        r_start <= 1'b0;
        r_end   <= (w_cnt_nxt == c_LAST);
      end else begin
        r_state <= S_IDLE;
        r_sr    <= '0;
        r_cnt   <= '0;
        r_d     <= 1'b0;
        r_start <= 1'b0;
        r_end   <= 1'b0;
      end
    end
  end

  assign ready        = w_ready;
  assign busy         = (r_state == S_SHIFT);
  assign d            = r_d;
  assign serial_start = r_start;
  assign serial_end   = r_end;
  assign counter      = r_cnt;
  assign overrun      = r_ovr;

endmodule
`default_nettype wire
